// File: rtl/alu_pkg.sv
// Shared definitions for the ALU dispatch stage: datapath sizes, the ALU
// select codes and the rule for which operations update the carry flag.
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 16;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_NOT   = 4'b0101,
        OP_SHL   = 4'b0110,
        OP_SHR   = 4'b0111,
        OP_ROL   = 4'b1000,
        OP_ROR   = 4'b1001,
        OP_PASSA = 4'b1010,
        OP_PASSB = 4'b1011,
        OP_NAND  = 4'b1100,
        OP_RSUB  = 4'b1101
    } alu_op_e;

    // Only the arithmetic operations produce a meaningful carry-out.
    function automatic logic writes_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_RSUB);
    endfunction

endpackage

// File: rtl/alu_dispatch_reg_file.sv
// Architectural register file: two combinational operand read ports, one
// combinational debug read port and one synchronous write port. r0 is
// hardwired to zero and never stores anything.
module reg_file #(
    parameter int  DATA_W   = 16,
    parameter int  NUM_REGS = 16,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);
    import alu_pkg::*;

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    assign regs[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] q_reg;

            // Each register loads only when the write port addresses it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_reg <= '0;
                end else if (wr_en && (wr_addr == REG_AW'(gi))) begin
                    q_reg <= wr_data;
                end
            end

            assign regs[gi] = q_reg;
        end
    endgenerate

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Single-issue execute/dispatch stage in front of an external combinational
// ALU. One execute register (E) holds the instruction being executed; its
// result is retired to the register file and the carry flag on the same edge
// the writeback handshake completes.
module alu_dispatch #(
    parameter int  DATA_W   = alu_pkg::DATA_W,
    parameter int  NUM_REGS = alu_pkg::NUM_REGS,
    localparam int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic              instr_imm_en,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              instr_use_c,
    output logic              alu_enable,
    output logic [3:0]        alu_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_c_in,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_c_out,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              carry_flag,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import alu_pkg::*;

    logic              e_valid_reg;
    logic [3:0]        e_op_reg;
    logic [REG_AW-1:0] e_rd_reg;
    logic [DATA_W-1:0] e_a_reg;
    logic [DATA_W-1:0] e_b_reg;
    logic              e_use_c_reg;
    logic              carry_reg;

    logic              accept;
    logic              retire;
    logic              wr_en;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] a_next;
    logic [DATA_W-1:0] b_next;

    assign instr_ready = !e_valid_reg || wb_ready;
    assign accept      = instr_valid && instr_ready;
    assign retire      = e_valid_reg && wb_ready;
    assign wr_en       = retire && (e_rd_reg != '0);

    reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr_a (instr_rs1),
        .rd_data_a (rf_a),
        .rd_addr_b (instr_rs2),
        .rd_data_b (rf_b),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .wr_en     (wr_en),
        .wr_addr   (e_rd_reg),
        .wr_data   (alu_out)
    );

    // Operand fetch: a result retiring on this edge is forwarded straight
    // from the ALU so a dependent instruction can issue back-to-back.
    always_comb begin
        a_next = '0;
        b_next = '0;
        if (instr_rs1 != '0) begin
            a_next = (wr_en && (e_rd_reg == instr_rs1)) ? alu_out : rf_a;
        end
        if (instr_imm_en) begin
            b_next = instr_imm;
        end else if (instr_rs2 != '0) begin
            b_next = (wr_en && (e_rd_reg == instr_rs2)) ? alu_out : rf_b;
        end
    end

    // Execute register: load on accept, empty on retire without a refill,
    // hold while the writeback port stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_valid_reg <= 1'b0;
            e_op_reg    <= '0;
            e_rd_reg    <= '0;
            e_a_reg     <= '0;
            e_b_reg     <= '0;
            e_use_c_reg <= 1'b0;
        end else if (accept) begin
            e_valid_reg <= 1'b1;
            e_op_reg    <= instr_op;
            e_rd_reg    <= instr_rd;
            e_a_reg     <= a_next;
            e_b_reg     <= b_next;
            e_use_c_reg <= instr_use_c;
        end else if (retire) begin
            e_valid_reg <= 1'b0;
        end
    end

    // Carry flag updates only when an arithmetic operation retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (retire && writes_carry(e_op_reg)) begin
            carry_reg <= alu_c_out;
        end
    end

    // ALU drive and writeback are gated to zero while E is empty.
    assign alu_enable = e_valid_reg;
    assign alu_sel    = e_valid_reg ? e_op_reg : '0;
    assign alu_a      = e_valid_reg ? e_a_reg : '0;
    assign alu_b      = e_valid_reg ? e_b_reg : '0;
    assign alu_c_in   = e_valid_reg && e_use_c_reg && carry_reg;
    assign wb_valid   = e_valid_reg;
    assign wb_rd      = e_valid_reg ? e_rd_reg : '0;
    assign wb_data    = e_valid_reg ? alu_out : '0;
    assign carry_flag = carry_reg;

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: a behavioural ALU closes the loop,
// a reference register/carry model predicts every retirement, and a
// scoreboard queue is checked whenever the writeback handshake fires.
`timescale 1ns/1ps
module tb_alu_dispatch;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [3:0]  instr_rd;
    logic [3:0]  instr_rs1;
    logic [3:0]  instr_rs2;
    logic        instr_imm_en;
    logic [15:0] instr_imm;
    logic        instr_use_c;
    logic        alu_enable;
    logic [3:0]  alu_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_c_in;
    logic [15:0] alu_out;
    logic        alu_c_out;
    logic        wb_valid;
    logic        wb_ready;
    logic [3:0]  wb_rd;
    logic [15:0] wb_data;
    logic        carry_flag;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } wb_t;

    wb_t         exp_q[$];
    logic [15:0] model_reg [16];
    logic        model_c;

    alu_dispatch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs1    (instr_rs1),
        .instr_rs2    (instr_rs2),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .instr_use_c  (instr_use_c),
        .alu_enable   (alu_enable),
        .alu_sel      (alu_sel),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_c_in     (alu_c_in),
        .alu_out      (alu_out),
        .alu_c_out    (alu_c_out),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .carry_flag   (carry_flag),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural ALU: {carry_out, result}; logic ops return carry 0.
    function automatic logic [16:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
        case (op)
            4'b0000: return {1'b0, a} + {1'b0, b} + 17'(cin);
            4'b0001: return {1'b0, a} - {1'b0, b} - 17'(cin);
            4'b1101: return {1'b0, b} - {1'b0, a} - 17'(cin);
            4'b0010: return {1'b0, a & b};
            4'b0011: return {1'b0, a | b};
            4'b0100: return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    assign {alu_c_out, alu_out} = alu_ref(alu_sel, alu_a, alu_b, alu_c_in);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every completed writeback handshake pops one expectation.
    always @(negedge clk) begin
        wb_t e;
        if (rst_n && wb_valid && wb_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no retirement", wb_rd, wb_data);
            end else begin
                e = exp_q.pop_front();
                if (wb_rd !== e.rd || wb_data !== e.data) begin
                    n_bad++;
                    $display("FAIL wb_result: got rd=%0d data=%h, required rd=%0d data=%h",
                             wb_rd, wb_data, e.rd, e.data);
                end else begin
                    $display("wb   rd=%0d data=%h", wb_rd, wb_data);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < 16; i++) model_reg[i] = 16'h0;
        model_c = 1'b0;
    endtask

    // Offer one instruction and wait (bounded) for it to be accepted; the
    // prediction is made at acceptance since retirement is in order.
    task automatic send(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                        input logic [3:0] rs2, input logic imm_en, input logic [15:0] imm,
                        input logic use_c);
        logic        ok;
        logic        rdy;
        logic [15:0] a;
        logic [15:0] b;
        logic [16:0] r;
        wb_t         e;
        ok           = 1'b0;
        instr_op     = op;
        instr_rd     = rd;
        instr_rs1    = rs1;
        instr_rs2    = rs2;
        instr_imm_en = imm_en;
        instr_imm    = imm;
        instr_use_c  = use_c;
        instr_valid  = 1'b1;
        #1;
        for (int i = 0; i < 20 && !ok; i++) begin
            rdy = instr_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got instr_ready=0 for 20 cycles, required acceptance");
        end else begin
            a = model_reg[rs1];
            b = imm_en ? imm : model_reg[rs2];
            r = alu_ref(op, a, b, use_c & model_c);
            if (rd != 4'd0) model_reg[rd] = r[15:0];
            if (op == 4'b0000 || op == 4'b0001 || op == 4'b1101) model_c = r[16];
            e.rd   = rd;
            e.data = r[15:0];
            exp_q.push_back(e);
            $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d imm_en=%0d imm=%h use_c=%0d exp=%h",
                     op, rd, rs1, rs2, imm_en, imm, use_c, r[15:0]);
        end
    endtask

    task automatic drain();
        instr_valid = 1'b0;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending retirements, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (instr_ready !== 1'b1 || wb_valid !== 1'b0 || alu_enable !== 1'b0 || carry_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got ready=%b wb_valid=%b en=%b c=%b, required 1 0 0 0",
                     instr_ready, wb_valid, alu_enable, carry_flag);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_sel, wb_rd, wb_data} !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got a=%h b=%h sel=%h rd=%h data=%h, required all 0",
                     alu_a, alu_b, alu_sel, wb_rd, wb_data);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        $display("reset released");
    endtask

    task automatic test_load_imm();
        send(OP_OR, 4'd1, 4'd0, 4'd0, 1'b1, 16'h1234, 1'b0);
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 4'd1 || wb_data !== 16'h1234) begin
            n_bad++;
            $display("FAIL load_latency: got wb_valid=%b rd=%0d data=%h, required 1 1 1234",
                     wb_valid, wb_rd, wb_data);
        end
        drain();
        dbg_addr = 4'd1;
        #1;
        n_cmp++;
        if (dbg_data !== 16'h1234) begin
            n_bad++;
            $display("FAIL load_dbg: got r1=%h, required 1234", dbg_data);
        end
    endtask

    task automatic test_back_to_back();
        send(OP_ADD, 4'd2, 4'd1, 4'd1, 1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: got instr_ready=%b, required 1", instr_ready);
        end
        send(OP_ADD, 4'd3, 4'd2, 4'd0, 1'b1, 16'h0001, 1'b0);
        n_cmp++;
        if (instr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready2: got instr_ready=%b, required 1", instr_ready);
        end
        drain();
        dbg_addr = 4'd3;
        #1;
        n_cmp++;
        if (dbg_data !== 16'h2469) begin
            n_bad++;
            $display("FAIL b2b_bypass: got r3=%h, required 2469", dbg_data);
        end
    endtask

    task automatic test_carry_chain();
        send(OP_OR, 4'd1, 4'd0, 4'd0, 1'b1, 16'hFFFF, 1'b0);
        send(OP_ADD, 4'd4, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b0);
        drain();
        n_cmp++;
        if (carry_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_set: got carry_flag=%b, required 1", carry_flag);
        end
        send(OP_ADD, 4'd5, 4'd0, 4'd0, 1'b0, 16'h0, 1'b1);
        n_cmp++;
        if (alu_c_in !== 1'b1 || alu_enable !== 1'b1) begin
            n_bad++;
            $display("FAIL carry_in: got c_in=%b en=%b, required 1 1", alu_c_in, alu_enable);
        end
        drain();
        dbg_addr = 4'd5;
        #1;
        n_cmp++;
        if (carry_flag !== 1'b0 || dbg_data !== 16'h0001) begin
            n_bad++;
            $display("FAIL carry_use: got c=%b r5=%h, required 0 0001", carry_flag, dbg_data);
        end
    endtask

    task automatic test_non_carry_op();
        send(OP_ADD, 4'd4, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b0);
        send(OP_XOR, 4'd6, 4'd1, 4'd1, 1'b0, 16'h0, 1'b0);
        drain();
        dbg_addr = 4'd6;
        #1;
        n_cmp++;
        if (carry_flag !== 1'b1 || dbg_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL xor_keeps_carry: got c=%b r6=%h, required 1 0000", carry_flag, dbg_data);
        end
    endtask

    task automatic test_backpressure();
        wb_ready = 1'b0;
        send(OP_ADD, 4'd7, 4'd1, 4'd0, 1'b1, 16'h0002, 1'b0);
        instr_op     = OP_ADD;
        instr_rd     = 4'd8;
        instr_rs1    = 4'd7;
        instr_rs2    = 4'd0;
        instr_imm_en = 1'b1;
        instr_imm    = 16'h0005;
        instr_use_c  = 1'b0;
        instr_valid  = 1'b1;
        dbg_addr     = 4'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (instr_ready !== 1'b0 || wb_valid !== 1'b1 || wb_data !== 16'h0001 || dbg_data !== 16'h0000) begin
                n_bad++;
                $display("FAIL stall_hold: got ready=%b wb_valid=%b data=%h r7=%h, required 0 1 0001 0000",
                         instr_ready, wb_valid, wb_data, dbg_data);
            end
            $display("stall cycle %0d", i);
            @(posedge clk);
        end
        #1;
        wb_ready = 1'b1;
        send(OP_ADD, 4'd8, 4'd7, 4'd0, 1'b1, 16'h0005, 1'b0);
        n_cmp++;
        if (dbg_data !== 16'h0001 || wb_rd !== 4'd8 || wb_data !== 16'h0006) begin
            n_bad++;
            $display("FAIL release: got r7=%h wb_rd=%0d wb_data=%h, required 0001 8 0006",
                     dbg_data, wb_rd, wb_data);
        end
        drain();
    endtask

    task automatic test_r0_and_reset();
        send(OP_ADD, 4'd0, 4'd1, 4'd0, 1'b1, 16'h0005, 1'b0);
        n_cmp++;
        if (wb_valid !== 1'b1 || wb_rd !== 4'd0) begin
            n_bad++;
            $display("FAIL r0_pulse: got wb_valid=%b rd=%0d, required 1 0", wb_valid, wb_rd);
        end
        drain();
        dbg_addr = 4'd0;
        #1;
        n_cmp++;
        if (dbg_data !== 16'h0000 || carry_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL r0_zero: got r0=%h c=%b, required 0000 1", dbg_data, carry_flag);
        end
        wb_ready = 1'b0;
        send(OP_ADD, 4'd9, 4'd1, 4'd0, 1'b1, 16'h0001, 1'b0);
        instr_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || alu_enable !== 1'b0 || carry_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got wb_valid=%b en=%b c=%b, required 0 0 0",
                     wb_valid, alu_enable, carry_flag);
        end
        for (int i = 1; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            n_cmp++;
            if (dbg_data !== 16'h0000) begin
                n_bad++;
                $display("FAIL reset_reg: got r%0d=%h, required 0000", i, dbg_data);
            end
        end
        exp_q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        wb_ready = 1'b1;
        $display("reset during stall applied");
        send(OP_OR, 4'd1, 4'd0, 4'd0, 1'b1, 16'hABCD, 1'b0);
        drain();
        dbg_addr = 4'd1;
        #1;
        n_cmp++;
        if (dbg_data !== 16'hABCD) begin
            n_bad++;
            $display("FAIL post_reset: got r1=%h, required abcd", dbg_data);
        end
    endtask

    initial begin
        instr_valid  = 1'b0;
        instr_op     = 4'd0;
        instr_rd     = 4'd0;
        instr_rs1    = 4'd0;
        instr_rs2    = 4'd0;
        instr_imm_en = 1'b0;
        instr_imm    = 16'h0;
        instr_use_c  = 1'b0;
        wb_ready     = 1'b1;
        dbg_addr     = 4'd0;
        model_clear();
        test_reset();
        test_load_imm();
        test_back_to_back();
        test_carry_chain();
        test_non_carry_op();
        test_backpressure();
        test_r0_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_dispatch.md
Name: alu_dispatch

Overview:
- Single-issue execute/dispatch stage that sits directly upstream of the 16-bit ALU and also retires its results.
- Holds the architectural register file and the carry flag.
- Accepts decoded instructions over a valid/ready handshake, reads operands with bypass, and drives the ALU's operand, select, carry-in and enable inputs.
- Captures the ALU result and carry-out, writes them back, and presents each retirement on a valid/ready writeback port.

Parameters:
- DATA_W, 16, operand/result width (must match ALU).
- NUM_REGS, 16, architectural registers; r0 reads as zero.
- REG_AW, $clog2(NUM_REGS), register address width (derived, not overridable).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- instr_valid  input  1  instruction offered.
- instr_ready  output  1  stage can accept this cycle.
- instr_op  input  4  ALU select code.
- instr_rd  input  REG_AW  destination register.
- instr_rs1  input  REG_AW  source A register.
- instr_rs2  input  REG_AW  source B register.
- instr_imm_en  input  1  B operand = instr_imm instead of rs2.
- instr_imm  input  DATA_W  immediate.
- instr_use_c  input  1  carry-in = carry flag (else 0).
- alu_enable  output  1  ALU enable.
- alu_sel  output  4  ALU select.
- alu_a  output  DATA_W  ALU A operand.
- alu_b  output  DATA_W  ALU B operand.
- alu_c_in  output  1  ALU carry-in.
- alu_out  input  DATA_W  ALU result, combinational from ALU inputs.
- alu_c_out  input  1  ALU carry-out.
- wb_valid  output  1  result retiring.
- wb_ready  input  1  downstream accepts retirement.
- wb_rd  output  REG_AW  retiring destination.
- wb_data  output  DATA_W  retiring result.
- carry_flag  output  1  architectural carry.
- dbg_addr  input  REG_AW  debug read address.
- dbg_data  output  DATA_W  debug read data, combinational; r0 returns 0.

Behaviour:
- One execute register E holds valid, op, rd, A, B and use_c.
- Reset (async, rst_n=0):
  - e_valid=0, every register=0, carry_flag=0.
  - Consequently alu_enable=0, wb_valid=0, instr_ready=1; alu_a/alu_b/alu_sel/wb_rd/wb_data reset to 0.
  - Reset mid-operation discards E with no writeback.
- Handshake:
  - instr_ready = !e_valid || wb_ready.
  - Accept when instr_valid && instr_ready; E loads at that edge.
  - Throughput is 1 instruction/cycle with wb_ready held high.
- Execute (E valid):
  - alu_enable=1, alu_sel=e_op, alu_a=e_A, alu_b=e_B, alu_c_in=e_use_c & carry_flag, sampled live.
  - wb_valid=e_valid; wb_data=alu_out; wb_rd=e_rd.
  - Latency from accept to wb_valid is 1 cycle.
- Retire when e_valid && wb_ready:
  - reg[e_rd] <= alu_out unless e_rd==0.
  - carry_flag <= alu_c_out only for ops 0000, 0001, 1101; all other ops leave it unchanged.
  - If no new accept at that edge, e_valid <= 0.
- Stall (e_valid && !wb_ready): E, the registers and carry_flag hold; outputs stay stable.
- Operand read at accept:
  - rs==0 gives 0.
  - Else if E retires at the same edge and e_rd==rs (rd!=0), bypass alu_out.
  - Else reg[rs].
  - B uses instr_imm when instr_imm_en=1.
- Carry hazard: none. carry_flag is read at execute time, so a back-to-back use_c instruction sees the prior retirement's carry.
- When E is idle, alu_enable=0 and the ALU inputs are don't-care; drive them to 0.
- Debug port: reads the register array only, with no bypass.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum of the 14 select codes (ADD=0000 … RSUB=1101).
  - Function writes_carry(op).
  - Localparams DATA_W, NUM_REGS.
- Sub-module reg_file:
  - 2 combinational read ports + 1 debug read port, 1 synchronous write port, async reset to 0.
  - r0 hardwired zero.
  - Bypass logic stays in alu_dispatch.

Test Plan:
- Reset then r1<=imm 0x1234 (op OR, rs1=0, imm_en) → wb_valid next cycle, wb_data=0x1234; dbg_addr=1 reads 0x1234 after retire.
- Back-to-back:
  - ADD r2=r1+r1, then ADD r3=r2+imm 1, wb_ready=1 → bypass gives r3=0x2469.
  - instr_ready stays 1 throughout.
- Carry chain:
  - r1=0xFFFF, ADD r4=r1+imm 1 → wb_data=0x0000, carry_flag=1.
  - Next ADD r5=r0+r0 with use_c=1 → alu_c_in=1, r5=0x0001, carry_flag=0.
- Non-carry op: with carry_flag=1, XOR r6=r1^r1 → r6=0, carry_flag stays 1.
- Backpressure:
  - Hold wb_ready=0 for 3 cycles with E valid → instr_ready=0, wb_data stable, no register write.
  - Release → exactly one write, and the queued instruction is accepted that same edge.
- r0/reset:
  - Write rd=0 → r0 still reads 0 and wb_valid still pulses.
  - Assert rst_n=0 while stalled → wb_valid=0 immediately, all registers 0, carry_flag=0.
